// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: tick-paced multiplexed 7-segment scanner with blanking and per-frame value capture
module seg7_scan_driver #(
   parameter int NUM_DIGITS = 4,
   parameter int BLANK_TICKS = 1,
   parameter bit SEG_ACTIVE_LOW = 1,
   parameter bit DIGIT_ACTIVE_LOW = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_tick,
   input  logic                    i_enable,
   input  logic [4*NUM_DIGITS-1:0] i_value,
   input  logic [NUM_DIGITS-1:0]   i_dp,
   input  logic                    i_blank_lz,
   output logic [6:0]              o_seg,
   output logic                    o_dp,
   output logic [NUM_DIGITS-1:0]   o_digit,
   output logic                    o_frame
);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
   localparam logic [3:0] BLANK_INIT = 4'(BLANK_TICKS > 0 ? BLANK_TICKS - 1 : 0);
   localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIGIT_ACTIVE_LOW ? '1 : '0;
   localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

   state_t                  state, state_n;
   logic [IW-1:0]           idx, idx_n;
   logic [3:0]              bcnt, bcnt_n;
   logic [4*NUM_DIGITS-1:0] sh_value, sh_value_n;
   logic [NUM_DIGITS-1:0]   sh_dp, sh_dp_n;
   logic                    sh_lz, sh_lz_n;
   logic                    frame_n, capture, lz_blank, dp_n;
   logic [3:0]              nib;
   logic [6:0]              seg_act, seg_n;
   logic [NUM_DIGITS-1:0]   dig_act, digit_n;

   // scan sequencing: enable drop wins, then tick-driven SHOW/BLANK stepping with wrap and recapture
   always_comb begin
      state_n = state;
      idx_n   = idx;
      bcnt_n  = bcnt;
      frame_n = 1'b0;
      capture = 1'b0;
      if (!i_enable) begin
         state_n = IDLE;
         idx_n   = '0;
         bcnt_n  = '0;
      end else if (state == IDLE) begin
         state_n = SHOW;
         idx_n   = '0;
         capture = 1'b1;
      end else if (i_tick) begin
         if (state == SHOW && BLANK_TICKS > 0) begin
            state_n = BLANK;
            bcnt_n  = BLANK_INIT;
         end else if (state == BLANK && bcnt != 4'd0) begin
            bcnt_n = bcnt - 4'd1;
         end else begin
            state_n = SHOW;
            idx_n   = (idx == LAST) ? '0 : idx + IW'(1);
            frame_n = (idx == LAST);
            capture = (idx == LAST);
         end
      end
      sh_value_n = capture ? i_value : sh_value;
      sh_dp_n    = capture ? i_dp : sh_dp;
      sh_lz_n    = capture ? i_blank_lz : sh_lz;
   end

   // output decode from the next state so the registered pins track state with no extra lag
   always_comb begin
      nib      = sh_value_n[{idx_n, 2'b00} +: 4];
      lz_blank = sh_lz_n && idx_n != '0 && (sh_value_n >> {idx_n, 2'b00}) == '0;
      seg_act  = (state_n == SHOW && !lz_blank) ? HEX[nib] : 7'h00;
      seg_n    = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
      dp_n     = (state_n == SHOW && sh_dp_n[idx_n]) ^ SEG_ACTIVE_LOW;
      dig_act  = (state_n == SHOW) ? NUM_DIGITS'(1) << idx_n : '0;
      digit_n  = DIGIT_ACTIVE_LOW ? ~dig_act : dig_act;
   end

   // state, shadows and pins, all cleared asynchronously
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= IDLE;
         idx      <= '0;
         bcnt     <= '0;
         sh_value <= '0;
         sh_dp    <= '0;
         sh_lz    <= 1'b0;
         o_seg    <= SEG_OFF;
         o_dp     <= SEG_ACTIVE_LOW;
         o_digit  <= DIG_OFF;
         o_frame  <= 1'b0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         bcnt     <= bcnt_n;
         sh_value <= sh_value_n;
         sh_dp    <= sh_dp_n;
         sh_lz    <= sh_lz_n;
         o_seg    <= seg_n;
         o_dp     <= dp_n;
         o_digit  <= digit_n;
         o_frame  <= frame_n;
      end
   end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of the scanner with blanking off and with two blank ticks
module tb_seg7_scan_driver;
   logic        clk = 1'b0, rst = 1'b1, tick = 1'b0, en = 1'b0, lz = 1'b0;
   logic [15:0] val = '0;
   logic [3:0]  dp = '0;
   logic [6:0]  seg0, seg2;
   logic        dp0, dp2, fr0, fr2;
   logic [3:0]  dig0, dig2;
   int          total = 0, bad = 0;
   logic [3:0]  exp_dig2 [12] = '{4'hF, 4'hF, 4'hD, 4'hF, 4'hF, 4'hB, 4'hF, 4'hF, 4'h7, 4'hF, 4'hF, 4'hE};

   always #5 clk = ~clk;

   seg7_scan_driver #(.NUM_DIGITS(4), .BLANK_TICKS(0)) d0 (
      .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_enable(en), .i_value(val), .i_dp(dp),
      .i_blank_lz(lz), .o_seg(seg0), .o_dp(dp0), .o_digit(dig0), .o_frame(fr0));

   seg7_scan_driver #(.NUM_DIGITS(4), .BLANK_TICKS(2)) d2 (
      .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_enable(en), .i_value(val), .i_dp(dp),
      .i_blank_lz(lz), .o_seg(seg2), .o_dp(dp2), .o_digit(dig2), .o_frame(fr2));

   function automatic logic [6:0] sl(input logic [6:0] h);
      return ~h;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic edge1;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse;
      tick = 1'b1;
      edge1();
      tick = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      edge1();
      rst = 1'b0;
   endtask

   initial begin
      repeat (3) edge1();
      chk("rst_seg0", seg0, 7'h7F);
      chk("rst_dig0", dig0, 4'hF);
      chk("rst_dp0", dp0, 1'b1);
      chk("rst_fr0", fr0, 1'b0);
      chk("rst_dig2", dig2, 4'hF);
      chk("rst_seg2", seg2, 7'h7F);
      val = 16'h1234;
      dp = 4'b0010;
      en = 1'b1;
      rst = 1'b0;
      edge1();
      chk("en_dig", dig0, 4'hE);
      chk("en_seg", seg0, sl(7'h66));
      chk("en_dp", dp0, 1'b1);
      pulse();
      chk("d1_dig", dig0, 4'hD);
      chk("d1_seg", seg0, sl(7'h4F));
      chk("d1_dp", dp0, 1'b0);
      val = 16'hABCD;
      pulse();
      chk("d2_dig", dig0, 4'hB);
      chk("d2_seg_old", seg0, sl(7'h5B));
      pulse();
      chk("d3_dig", dig0, 4'h7);
      chk("d3_seg_old", seg0, sl(7'h06));
      chk("d3_fr", fr0, 1'b0);
      pulse();
      chk("wrap_dig", dig0, 4'hE);
      chk("wrap_seg_new", seg0, sl(7'h5E));
      chk("wrap_fr", fr0, 1'b1);
      edge1();
      chk("wrap_fr_gone", fr0, 1'b0);
      chk("wrap_hold_seg", seg0, sl(7'h5E));
      val = 16'h1234;
      dp = '0;
      do_reset();
      edge1();
      chk("bl_start_dig", dig2, 4'hE);
      chk("bl_start_seg", seg2, sl(7'h66));
      chk("bl_start_fr", fr2, 1'b0);
      for (int i = 0; i < 12; i++) begin
         repeat (4) edge1();
         pulse();
         chk($sformatf("bl_dig_t%0d", i + 1), dig2, exp_dig2[i]);
         chk($sformatf("bl_fr_t%0d", i + 1), fr2, 8'(i == 11));
      end
      pulse();
      chk("pre_ar_dig2", dig2, 4'hF);
      chk("pre_ar_dig0", dig0, 4'hD);
      #3 rst = 1'b1;
      #1;
      chk("ar_dig0", dig0, 4'hF);
      chk("ar_seg0", seg0, 7'h7F);
      chk("ar_dig2", dig2, 4'hF);
      #2 rst = 1'b0;
      edge1();
      chk("ar_restart_dig2", dig2, 4'hE);
      chk("ar_restart_dig0", dig0, 4'hE);
      val = 16'h0050;
      lz = 1'b1;
      do_reset();
      edge1();
      chk("lz_d0_dig", dig0, 4'hE);
      chk("lz_d0_seg", seg0, sl(7'h3F));
      pulse();
      chk("lz_d1_dig", dig0, 4'hD);
      chk("lz_d1_seg", seg0, sl(7'h6D));
      tick = 1'b1;
      edge1();
      chk("lz_d2_dig", dig0, 4'hB);
      chk("lz_d2_seg", seg0, 7'h7F);
      edge1();
      chk("lz_d3_dig", dig0, 4'h7);
      chk("lz_d3_seg", seg0, 7'h7F);
      tick = 1'b0;
      val = 16'h0000;
      dp = 4'b0010;
      pulse();
      chk("z_d0_dig", dig0, 4'hE);
      chk("z_d0_seg", seg0, sl(7'h3F));
      chk("z_d0_fr", fr0, 1'b1);
      pulse();
      chk("z_d1_dig", dig0, 4'hD);
      chk("z_d1_seg", seg0, 7'h7F);
      chk("z_d1_dp", dp0, 1'b0);
      pulse();
      chk("drop_pre_dig", dig0, 4'hB);
      en = 1'b0;
      tick = 1'b1;
      edge1();
      tick = 1'b0;
      chk("drop_dig", dig0, 4'hF);
      chk("drop_seg", seg0, 7'h7F);
      chk("drop_dp", dp0, 1'b1);
      chk("drop_fr", fr0, 1'b0);
      edge1();
      en = 1'b1;
      edge1();
      chk("reen_dig", dig0, 4'hE);
      chk("reen_seg", seg0, sl(7'h3F));
      chk("reen_fr", fr0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
